// File: rtl/dt_pkg.sv
// Shared constants and types for the distance-transform result RAM arbiter.
package dt_pkg;

    localparam int AW = 14;
    localparam int DW = 8;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } own_e;

endpackage

// File: rtl/dt_arb_lock_timer.sv
// Lock-ownership idle timer: counts owner-idle cycles and pulses expire on the
// LOCK_TMO-th consecutive idle cycle, then restarts from zero.
module dt_arb_lock_timer #(
    parameter int LOCK_TMO = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic idle,
    output logic expire
);

    localparam int CW = $clog2(LOCK_TMO + 1);
    localparam logic [CW-1:0] LAST_IDLE = CW'(LOCK_TMO - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // Fires during the final idle cycle so the release lands on the next edge.
    assign expire = idle && !clear && (count_reg == LAST_IDLE);

    always_comb begin
        count_next = count_reg;
        if (clear || expire) begin
            count_next = '0;
        end else if (idle) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/dt_res_arbiter.sv
// Two-master arbiter for the single-port DT result RAM with lock ownership,
// lock timeout and a 3-cycle registered read return. Define RES_ARB_RR_EN for
// round-robin contention; otherwise master 0 has fixed priority.
module dt_res_arbiter
    import dt_pkg::*;
#(
    parameter int AW       = dt_pkg::AW,
    parameter int DW       = dt_pkg::DW,
    parameter int LOCK_TMO = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          wr0,
    input  logic          wr1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          lock_err,
    output logic          res_wr,
    output logic          res_rd,
    output logic [AW-1:0] res_addr,
    output logic [DW-1:0] res_do,
    input  logic [DW-1:0] res_di
);

    own_e state_reg;
    own_e state_next;

    logic          win_m1;
    logic          acc;
    logic          acc_m;
    logic          acc_wr;
    logic          acc_lock;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;

    logic          owner_idle;
    logic          tmr_clear;
    logic          tmr_expire;

    logic          res_wr_reg;
    logic          res_rd_reg;
    logic [AW-1:0] res_addr_reg;
    logic [DW-1:0] res_do_reg;
    logic          tag1_reg;
    logic          rd2_reg;
    logic          tag2_reg;
    logic          rvalid_reg [2];
    logic [DW-1:0] rdata_reg  [2];

`ifdef RES_ARB_RR_EN
    logic rr_last_reg;

    // Pointer follows every accept, including commands issued under a lock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_last_reg <= M1;
        end else if (acc) begin
            rr_last_reg <= acc_m;
        end
    end

    assign win_m1 = (rr_last_reg == M0);
`else
    assign win_m1 = 1'b0;
`endif

    // Grant looks only at requests, ownership and the contention winner.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state_reg)
            OWN_M0: gnt0 = req0;
            OWN_M1: gnt1 = req1;
            default: begin
                gnt0 = req0 && (!req1 || !win_m1);
                gnt1 = req1 && (!req0 || win_m1);
            end
        endcase
    end

    assign acc       = gnt0 || gnt1;
    assign acc_m     = gnt1;
    assign acc_wr    = gnt1 ? wr1    : wr0;
    assign acc_lock  = gnt1 ? lock1  : lock0;
    assign acc_addr  = gnt1 ? addr1  : addr0;
    assign acc_wdata = gnt1 ? wdata1 : wdata0;

    assign owner_idle = ((state_reg == OWN_M0) && !req0) ||
                        ((state_reg == OWN_M1) && !req1);
    assign tmr_clear  = acc || (state_reg == OWN_NONE);

    dt_arb_lock_timer #(
        .LOCK_TMO (LOCK_TMO)
    ) u_lock_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .idle   (owner_idle),
        .expire (tmr_expire)
    );

    assign lock_err = tmr_expire;

    always_comb begin
        state_next = state_reg;
        if (acc) begin
            if (!acc_lock) begin
                state_next = OWN_NONE;
            end else if (acc_m) begin
                state_next = OWN_M1;
            end else begin
                state_next = OWN_M0;
            end
        end else if (tmr_expire) begin
            state_next = OWN_NONE;
        end
    end

    // Stage 1 drives the RAM pins; stage 2 tracks the read while res_di settles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= OWN_NONE;
            res_wr_reg   <= 1'b0;
            res_rd_reg   <= 1'b0;
            res_addr_reg <= '0;
            res_do_reg   <= '0;
            tag1_reg     <= M0;
            rd2_reg      <= 1'b0;
            tag2_reg     <= M0;
        end else begin
            state_reg  <= state_next;
            res_wr_reg <= acc && acc_wr;
            res_rd_reg <= acc && !acc_wr;
            if (acc) begin
                res_addr_reg <= acc_addr;
                tag1_reg     <= acc_m;
            end
            // Write data only changes on writes so res_do keeps the last written value.
            if (acc && acc_wr) begin
                res_do_reg <= acc_wdata;
            end
            rd2_reg  <= res_rd_reg;
            tag2_reg <= tag1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ret
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rvalid_reg[gi] <= 1'b0;
                    rdata_reg[gi]  <= '0;
                end else begin
                    rvalid_reg[gi] <= rd2_reg && (tag2_reg == 1'(gi));
                    if (rd2_reg && (tag2_reg == 1'(gi))) begin
                        rdata_reg[gi] <= res_di;
                    end
                end
            end
        end
    endgenerate

    assign res_wr   = res_wr_reg;
    assign res_rd   = res_rd_reg;
    assign res_addr = res_addr_reg;
    assign res_do   = res_do_reg;
    assign rvalid0  = rvalid_reg[0];
    assign rvalid1  = rvalid_reg[1];
    assign rdata0   = rdata_reg[0];
    assign rdata1   = rdata_reg[1];

endmodule

// File: tb/tb_dt_res_arbiter.sv
// Scoreboard bench for dt_res_arbiter: directed commands push expected RAM
// strobes and read returns; monitors pop and compare when the DUT presents them.
module tb_dt_res_arbiter;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        req0   = 1'b0;
    logic        req1   = 1'b0;
    logic        wr0    = 1'b0;
    logic        wr1    = 1'b0;
    logic        lock0  = 1'b0;
    logic        lock1  = 1'b0;
    logic [13:0] addr0  = '0;
    logic [13:0] addr1  = '0;
    logic [7:0]  wdata0 = '0;
    logic [7:0]  wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, lock_err, res_wr, res_rd;
    logic [7:0]  rdata0, rdata1, res_do;
    logic [13:0] res_addr;
    logic [7:0]  res_di = '0;

    dt_res_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .wr0      (wr0),
        .wr1      (wr1),
        .lock0    (lock0),
        .lock1    (lock1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .lock_err (lock_err),
        .res_wr   (res_wr),
        .res_rd   (res_rd),
        .res_addr (res_addr),
        .res_do   (res_do),
        .res_di   (res_di)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one-cycle registered read.
    logic [7:0] ram [0:16383];
    always @(posedge clk) begin
        if (res_wr) ram[res_addr] <= res_do;
        if (res_rd) res_di <= ram[res_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic        wr;
        logic [13:0] addr;
        logic [7:0]  data;
    } cmd_t;

    typedef struct {
        int         due;
        logic       m;
        logic [7:0] data;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    cmd_t mc;
    rsp_t mr;
    int   n_chk   = 0;
    int   n_pass  = 0;
    bit   push_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic set_m0(input logic r, input logic w, input logic l,
                          input logic [13:0] a, input logic [7:0] d);
        req0 = r; wr0 = w; lock0 = l; addr0 = a; wdata0 = d;
    endtask

    task automatic set_m1(input logic r, input logic w, input logic l,
                          input logic [13:0] a, input logic [7:0] d);
        req1 = r; wr1 = w; lock1 = l; addr1 = a; wdata1 = d;
    endtask

    task automatic set_idle();
        set_m0(1'b0, 1'b0, 1'b0, 14'd0, 8'd0);
        set_m1(1'b0, 1'b0, 1'b0, 14'd0, 8'd0);
    endtask

    // One bus cycle: check grants/lock_err, queue expectations for the accepted command.
    task automatic tick(input string name, input logic eg0, input logic eg1,
                        input logic [7:0] erd, input logic ele);
        logic        w;
        logic [13:0] a;
        logic [7:0]  d;
        @(negedge clk);
        check({name, " gnt0"}, gnt0, eg0);
        check({name, " gnt1"}, gnt1, eg1);
        check({name, " lock_err"}, lock_err, ele);
        if (push_en && (eg0 || eg1)) begin
            w = eg1 ? wr1 : wr0;
            a = eg1 ? addr1 : addr0;
            d = eg1 ? wdata1 : wdata0;
            cmd_q.push_back('{cyc + 1, w, a, d});
            if (!w) rsp_q.push_back('{cyc + 3, eg1, erd});
            $display("cycle %0d %s: m%0d %s addr %0d data %02h", cyc, name, eg1,
                     w ? "wr" : "rd", a, w ? d : erd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " gnt0"}, gnt0, 1'b0);
        check({tag, " gnt1"}, gnt1, 1'b0);
        check({tag, " rvalid0"}, rvalid0, 1'b0);
        check({tag, " rvalid1"}, rvalid1, 1'b0);
        check({tag, " lock_err"}, lock_err, 1'b0);
        check({tag, " res_wr"}, res_wr, 1'b0);
        check({tag, " res_rd"}, res_rd, 1'b0);
        check({tag, " res_addr"}, res_addr, 14'd0);
        check({tag, " res_do"}, res_do, 8'd0);
        check({tag, " rdata0"}, rdata0, 8'd0);
        check({tag, " rdata1"}, rdata1, 8'd0);
    endtask

    // Monitors: RAM strobes and read returns are compared against the queues.
    always @(negedge clk) begin
        if (reset) begin
            if (res_wr || res_rd) begin
                if (cmd_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_cmd: got wr=%0b rd=%0b addr %0d required none", res_wr, res_rd, res_addr);
                end else begin
                    mc = cmd_q.pop_front();
                    check("cmd_cycle", cyc, mc.due);
                    check("cmd_wr", res_wr, mc.wr);
                    check("cmd_rd", res_rd, !mc.wr);
                    check("cmd_addr", res_addr, mc.addr);
                    if (mc.wr) check("cmd_data", res_do, mc.data);
                end
            end
            if (rvalid0 || rvalid1) begin
                check("rvalid_excl", rvalid0 && rvalid1, 1'b0);
                if (rsp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_rvalid: got rvalid0=%0b rvalid1=%0b required none", rvalid0, rvalid1);
                end else begin
                    mr = rsp_q.pop_front();
                    check("rsp_cycle", cyc, mr.due);
                    check("rsp_master", rvalid1, mr.m);
                    check("rsp_data", mr.m ? rdata1 : rdata0, mr.data);
                    $display("cycle %0d return m%0d data %02h", cyc, rvalid1, rvalid1 ? rdata1 : rdata0);
                end
            end
        end
    end

    initial begin
        logic eg0;
        set_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("por");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Preload writes; the first also checks write strobe and address hold.
        set_m0(1, 1, 0, 14'd129, 8'h05);       tick("wr129", 1, 0, 8'h00, 0);
        set_idle();                             tick("idle", 0, 0, 8'h00, 0);
        check("hold_addr", res_addr, 14'd129);
        check("hold_do", res_do, 8'h05);
        set_m1(1, 1, 0, 14'd16383, 8'h7F);      tick("wr16383", 0, 1, 8'h00, 0);
        set_idle();
        set_m0(1, 1, 0, 14'd20, 8'h11);         tick("wr20", 1, 0, 8'h00, 0);
        set_m0(1, 1, 0, 14'd21, 8'h22);         tick("wr21", 1, 0, 8'h00, 0);
        set_idle();
        set_m1(1, 1, 0, 14'd30, 8'h33);         tick("wr30", 0, 1, 8'h00, 0);
        set_m1(1, 1, 0, 14'd31, 8'h44);         tick("wr31", 0, 1, 8'h00, 0);
        set_idle();

        // Write then read same address, then a back-to-back read from the other master.
        set_m0(1, 1, 0, 14'd50, 8'hA5);         tick("wr50", 1, 0, 8'h00, 0);
        set_m0(1, 0, 0, 14'd50, 8'h00);         tick("rd50", 1, 0, 8'hA5, 0);
        set_idle();
        set_m1(1, 0, 0, 14'd16383, 8'h00);      tick("rd16383", 0, 1, 8'h7F, 0);
        set_idle();
        repeat (4) tick("idle", 0, 0, 8'h00, 0);

        // Contention: both masters read for 4 cycles.
        for (int i = 0; i < 4; i++) begin
            set_m0(1, 0, 0, 14'd20, 8'h00);
            set_m1(1, 0, 0, 14'd30, 8'h00);
`ifdef RES_ARB_RR_EN
            eg0 = (i % 2 == 0);
`else
            eg0 = 1'b1;
`endif
            tick("contend", eg0, !eg0, eg0 ? 8'h11 : 8'h33, 0);
        end
        set_idle();
        repeat (4) tick("idle", 0, 0, 8'h00, 0);

        // Lock burst by m1 while m0 keeps requesting.
        set_m1(1, 0, 1, 14'd30, 8'h00);         tick("burst0", 0, 1, 8'h33, 0);
        set_m0(1, 0, 0, 14'd21, 8'h00);
        set_m1(1, 0, 1, 14'd31, 8'h00);         tick("burst1", 0, 1, 8'h44, 0);
        set_m1(1, 0, 1, 14'd30, 8'h00);         tick("burst2", 0, 1, 8'h33, 0);
        set_m1(1, 0, 0, 14'd31, 8'h00);         tick("burst3", 0, 1, 8'h44, 0);
        set_m1(1, 0, 0, 14'd30, 8'h00);         tick("after_burst", 1, 0, 8'h22, 0);
        set_m0(0, 0, 0, 14'd0, 8'h00);          tick("m1_again", 0, 1, 8'h33, 0);
        set_idle();
        repeat (4) tick("idle", 0, 0, 8'h00, 0);

        // Lock timeout: m0 locks then goes idle while m1 waits.
        set_m0(1, 1, 1, 14'd60, 8'h66);         tick("lock_wr60", 1, 0, 8'h00, 0);
        set_m0(0, 0, 0, 14'd0, 8'h00);
        set_m1(1, 0, 0, 14'd60, 8'h00);
        for (int i = 1; i <= 16; i++) begin
            tick("tmo_wait", 0, 0, 8'h00, i == 16);
        end
        tick("tmo_release", 0, 1, 8'h66, 0);
        set_idle();
        repeat (4) tick("idle", 0, 0, 8'h00, 0);

        // Reset while a read is in flight: the return must be dropped.
        push_en = 1'b0;
        set_m0(1, 0, 0, 14'd129, 8'h00);        tick("rd_killed", 1, 0, 8'h05, 0);
        set_idle();
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("mid");
        @(posedge clk);
        #1;
        reset   = 1'b1;
        push_en = 1'b1;
        repeat (8) tick("post_rst", 0, 0, 8'h00, 0);

        check("cmd_q_drained", cmd_q.size(), 0);
        check("rsp_q_drained", rsp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
